// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the data memory (port 0 = CPU, port 1 = debug/DMA).
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with port 0 winning.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                winner;
  logic                grant;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;
  logic                start;

  assign start = (state == IDLE) && (p0_req || p1_req);

`ifdef DMEM_ARB_RR_EN
  // last_grant starts at 1 so that port 0 wins the first contended access
  logic last_grant;

  always_comb begin
    winner = 1'b0;
    if (p0_req && p1_req)
      winner = ~last_grant;
    else if (p1_req)
      winner = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (start)
      last_grant <= winner;
  end
`else
  assign winner = ~p0_req & p1_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (p0_req || p1_req) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    busy   = 1'b0;
    p0_ack = 1'b0;
    p1_ack = 1'b0;
    case (state)
      ACCESS: begin
        busy   = 1'b1;
        mem_we = lat_we;
      end
      DONE: begin
        busy   = 1'b1;
        p0_ack = ~grant;
        p1_ack = grant;
      end
      default: ;
    endcase
  end

  // The winner's request is captured once, so later input changes cannot disturb the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (start) begin
      grant     <= winner;
      lat_we    <= winner ? p1_we    : p0_we;
      lat_addr  <= winner ? p1_addr  : p0_addr;
      lat_wdata <= winner ? p1_wdata : p0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata_q <= '0;
    else if (state == ACCESS && !lat_we)
      rdata_q <= mem_rdata;
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model plus directed scenarios.
// Honours DMEM_ARB_RR_EN in its arbitration model and expected ack orders.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [15:0] p0_addr = '0;
  logic [31:0] p0_wdata = '0;
  logic        p0_ack;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [15:0] p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic        p1_ack;
  logic [31:0] rdata;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Emulated data memory: combinational read, write on the clock edge while mem_we is high
  logic [31:0] tb_mem  [0:65535];
  logic [31:0] ref_mem [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      tb_mem[i]  = {16'hC0DE, i[15:0]};
      ref_mem[i] = {16'hC0DE, i[15:0]};
    end
  end

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one access in flight, described by its age in cycles since the granting edge
  int          age = 3;
  logic        m_port = 1'b0;
  logic        m_we = 1'b0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_last = 1'b1;

  function automatic logic pick_port(input logic r0, input logic r1, input logic last);
`ifdef DMEM_ARB_RR_EN
    if (r0 && r1) return ~last;
`else
    if (r0 && r1) return 1'b0;
`endif
    return r1 && !r0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age     <= 3;
      m_port  <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rdata <= '0;
      m_last  <= 1'b1;
    end else begin
      if (age == 0) begin
        if (m_we) ref_mem[m_addr] <= m_wdata;
        else      m_rdata <= ref_mem[m_addr];
      end
      if (age >= 2 && (p0_req || p1_req)) begin
        m_port  <= pick_port(p0_req, p1_req, m_last);
        m_last  <= pick_port(p0_req, p1_req, m_last);
        m_we    <= pick_port(p0_req, p1_req, m_last) ? p1_we    : p0_we;
        m_addr  <= pick_port(p0_req, p1_req, m_last) ? p1_addr  : p0_addr;
        m_wdata <= pick_port(p0_req, p1_req, m_last) ? p1_wdata : p0_wdata;
        age     <= 0;
      end else if (age < 3) begin
        age <= age + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy",      busy,      age < 2);
      checkOutput("mem_we",    mem_we,    (age == 0) && m_we);
      checkOutput("p0_ack",    p0_ack,    (age == 1) && !m_port);
      checkOutput("p1_ack",    p1_ack,    (age == 1) && m_port);
      checkOutput("mem_addr",  mem_addr,  m_addr);
      checkOutput("mem_wdata", mem_wdata, m_wdata);
      checkOutput("rdata",     rdata,     m_rdata);
    end
  end

  // Event log used by the directed scenarios
  int          we_count = 0;
  int          last_we_cyc = 0;
  logic [15:0] last_we_addr = '0;
  int          p0_ack_count = 0;
  int          p1_ack_count = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      we_count     <= we_count + 1;
      last_we_cyc  <= cyc;
      last_we_addr <= mem_addr;
    end
    if (p0_ack) p0_ack_count <= p0_ack_count + 1;
    if (p1_ack) p1_ack_count <= p1_ack_count + 1;
  end

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [15:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic waitAck(input int port, input int budget, output int at, output logic [31:0] rd);
    at = -1;
    rd = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
        at = cyc;
        rd = rdata;
        break;
      end
    end
    if (at < 0) checkOutput($sformatf("p%0d_ack_timeout", port), 0, 1);
  endtask

  int          n, t0, t1, w0, c0;
  logic [31:0] rd;
  int          ack_port [4];
  int          ack_cyc  [4];
  int          exp_port [4];
  int          got;

  initial begin
    // Reset with random inputs: every output must be zero
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      applyStimulus(0, 1'($urandom), 1'($urandom), 16'($urandom), $urandom);
      applyStimulus(1, 1'($urandom), 1'($urandom), 16'($urandom), $urandom);
    end
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_acks", {p0_ack, p1_ack}, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    // Contention: p0 read and p1 write raised together
    @(posedge clk); #1;
    n = cyc;
    w0 = we_count;
    applyStimulus(0, 1, 0, 16'h0001, 32'h0);
    applyStimulus(1, 1, 1, 16'h0002, 32'hDEADBEEF);
    waitAck(0, 10, t0, rd);
    checkOutput("cont_p0_lat", t0 - n, 2);
    checkOutput("cont_p0_rdata", rd, 32'hC0DE0001);
    @(posedge clk); #1 applyStimulus(0, 0, 0, 0, 0);
    waitAck(1, 10, t1, rd);
    checkOutput("cont_p1_lat", t1 - n, 5);
    checkOutput("cont_we_cyc", last_we_cyc - n, 4);
    checkOutput("cont_we_cnt", we_count - w0, 1);
    @(posedge clk); #1 applyStimulus(1, 0, 0, 0, 0);

    // Both requests held for four accesses
`ifdef DMEM_ARB_RR_EN
    exp_port = '{0, 1, 0, 1};
`else
    exp_port = '{0, 0, 0, 0};
`endif
    @(posedge clk); #1;
    n = cyc;
    applyStimulus(0, 1, 0, 16'h0005, 32'h0);
    applyStimulus(1, 1, 0, 16'h0006, 32'h0);
    got = 0;
    for (int i = 0; i < 30 && got < 4; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        ack_port[got] = p1_ack ? 1 : 0;
        ack_cyc[got]  = cyc;
        got++;
      end
    end
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("hold_ack_count", got, 4);
    checkOutput("hold_first_lat", ack_cyc[0] - n, 2);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("hold_order%0d", i), ack_port[i], exp_port[i]);
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("hold_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);

    // Port 0 write then read back
    @(posedge clk); #1;
    n = cyc;
    w0 = we_count;
    applyStimulus(0, 1, 1, 16'h0003, 32'h12345678);
    waitAck(0, 10, t0, rd);
    checkOutput("p0w_lat", t0 - n, 2);
    checkOutput("p0w_we_cyc", last_we_cyc - n, 1);
    checkOutput("p0w_we_cnt", we_count - w0, 1);
    checkOutput("p0w_we_addr", last_we_addr, 16'h0003);
    @(posedge clk); #1 applyStimulus(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    n = cyc;
    applyStimulus(0, 1, 0, 16'h0003, 32'h0);
    waitAck(0, 10, t0, rd);
    checkOutput("p0r_lat", t0 - n, 2);
    checkOutput("p0r_rdata", rd, 32'h12345678);
    @(posedge clk); #1 applyStimulus(0, 0, 0, 0, 0);

    // Port 1 back-to-back reads: request held across the first ack
    c0 = p0_ack_count;
    @(posedge clk); #1;
    applyStimulus(1, 1, 0, 16'h0002, 32'h0);
    waitAck(1, 10, t0, rd);
    checkOutput("b2b_rdata0", rd, 32'hDEADBEEF);
    waitAck(1, 10, t1, rd);
    checkOutput("b2b_gap", t1 - t0, 3);
    checkOutput("b2b_rdata1", rd, 32'hDEADBEEF);
    @(posedge clk); #1 applyStimulus(1, 0, 0, 0, 0);
    checkOutput("b2b_no_p0_ack", p0_ack_count - c0, 0);

    // Reset during a port 1 write in ACCESS
    @(posedge clk); #1;
    applyStimulus(1, 1, 1, 16'h0010, 32'hCAFEF00D);
    @(posedge clk); #2;
    checkOutput("mid_we_before", mem_we, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_we_drop", mem_we, 0);
    checkOutput("mid_busy_drop", busy, 0);
    checkOutput("mid_ack_drop", p1_ack, 0);
    applyStimulus(1, 0, 0, 0, 0);
    c0 = p1_ack_count;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("mid_no_p1_ack", p1_ack_count - c0, 0);
    @(posedge clk); #1;
    n = cyc;
    applyStimulus(1, 1, 0, 16'h0010, 32'h0);
    waitAck(1, 10, t1, rd);
    checkOutput("post_rst_lat", t1 - n, 2);
    checkOutput("post_rst_rdata", rd, 32'hC0DE0010);
    @(posedge clk); #1 applyStimulus(1, 0, 0, 0, 0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the data memory of the multi-cycle processor.
- Port 0: CPU load/store path. Port 1: debug/DMA loader.
- Serialises requests from both ports onto the single memory port (16-bit word address, 32-bit data, single write enable, combinational read).
- Returns registered read data to the requester with a one-cycle acknowledge.

Parameters:
ADDR_W, 16, memory word-address width
DATA_W, 32, memory data width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
p0_req  input  1  port 0 access request, level
p0_we  input  1  port 0 write (1) / read (0)
p0_addr  input  ADDR_W  port 0 address
p0_wdata  input  DATA_W  port 0 write data
p0_ack  output  1  port 0 access complete, one-cycle pulse
p1_req  input  1  port 1 access request, level
p1_we  input  1  port 1 write / read
p1_addr  input  ADDR_W  port 1 address
p1_wdata  input  DATA_W  port 1 write data
p1_ack  output  1  port 1 access complete, one-cycle pulse
rdata  output  DATA_W  read data shared by both ports, valid while pN_ack=1 for a read
busy  output  1  high whenever state != IDLE
mem_addr  output  ADDR_W  to memory data_address
mem_we  output  1  to memory write_en
mem_wdata  output  DATA_W  to memory write_data
mem_rdata  input  DATA_W  from memory read_data

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; all outputs, address/data/we latches, and the grant register = 0.
- FSM has three states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - req is sampled only in this state.
  - If any req is high, select the winner and latch its we/addr/wdata and port id.
  - Next state is ACCESS. With no req, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr, mem_wdata and mem_we come from the latches.
  - mem_we is high only in ACCESS and only for a write.
  - On a read, rdata is loaded from mem_rdata at the closing edge. A write leaves rdata unchanged.
  - Next state is DONE.
- DONE (1 cycle):
  - The pN_ack of the granted port is 1; the other ack is 0.
  - Next state is IDLE.
- Latency: req sampled high in IDLE at cycle N -> mem_we/addr driven in N+1 -> ack in N+2. Maximum throughput is 1 access per 3 cycles.
- Requester rule:
  - Hold req, we, addr and wdata stable until ack is seen.
  - A req still high in the IDLE cycle after ack starts a new access. This is legal back-to-back behaviour, not an error.
- mem_addr and mem_wdata hold their last latched value outside ACCESS. mem_we is 0 outside ACCESS.
- Arbitration (default): fixed priority, p0 wins. A losing request stays pending and is served on the next IDLE.
- Both acks are never high in the same cycle. At most one access is in flight.
- Reset mid-operation:
  - mem_we, busy and both acks drop asynchronously.
  - A write in ACCESS is aborted and its commit is not guaranteed.
  - No ack is issued for an aborted access.
  - After rst_n rises, the FSM starts in IDLE.
- A req/addr change during ACCESS or DONE has no effect on the in-flight access.

Optional Feature:
DMEM_ARB_RR_EN
- Defined:
  - Round-robin arbitration using a last_grant register (reset value 1, so p0 wins first).
  - On simultaneous requests, the port not granted last wins.
  - A single requester always wins.
  - last_grant updates on the IDLE->ACCESS transition.
- Undefined: fixed priority, p0 wins, and no last_grant register exists.

Test Plan:
- Reset check: rst_n=0 with random inputs -> all outputs 0, busy=0. Release rst_n -> busy=0 until the first req.
- Port 0 write then read:
  - p0 write addr=0x0003, wdata=0x12345678 at N -> mem_we=1 with mem_addr=0x0003 only in N+1; p0_ack=1 in N+2.
  - Then p0 read addr=0x0003 -> rdata=0x12345678 while p0_ack=1.
- Contention, fixed priority: p0 read 0x0001 and p1 write 0x0002=0xDEADBEEF raised in the same cycle N -> p0_ack at N+2, p1_ack at N+5; mem_we high only in N+4.
- Round-robin (DMEM_ARB_RR_EN): both reqs held high for 4 accesses -> ack order p0,p1,p0,p1, spaced 3 cycles apart.
- Reset mid-access: assert rst_n=0 while in ACCESS on a p1 write -> mem_we and busy drop immediately, no p1_ack. After release, the next p1 read is served normally.
- Back-to-back from one port: p1 holds req across ack -> second access starts the cycle after DONE; acks 3 cycles apart; p0_ack stays 0 throughout.
